// File: rtl/cpu_pkg.sv
// Shared definitions for the branch prediction front end.
// Holds the prediction-mode encodings, the 2-bit saturating counter states
// and the fixed instruction size used by the next-PC adder.
package cpu_pkg;

    localparam int PRED_STATIC_NT = 0;
    localparam int PRED_BIMODAL   = 1;
    localparam int PRED_GSHARE    = 2;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t SNT = 2'b00;
    localparam ctr2_t WNT = 2'b01;
    localparam ctr2_t WT  = 2'b10;
    localparam ctr2_t ST  = 2'b11;

    localparam int INST_BYTES = 4;

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer.
// Ports:
//   clk, reset      - clock and synchronous active-high reset (clears valid bits)
//   rd_word         - word address (pc[XLEN-1:2]) of the fetch PC, combinational read
//   rd_hit          - entry valid and tag matches
//   rd_target       - stored target of the indexed entry
//   rd_uncond       - stored entry is an unconditional jump
//   wr_en           - write the entry selected by wr_word this clock edge
//   wr_word         - word address of the resolved instruction
//   wr_target       - target to store
//   wr_uncond       - 1 for jal/jalr
module branch_target_buffer #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-3:0] rd_word,
    output logic            rd_hit,
    output logic [XLEN-1:0] rd_target,
    output logic            rd_uncond,
    input  logic            wr_en,
    input  logic [XLEN-3:0] wr_word,
    input  logic [XLEN-1:0] wr_target,
    input  logic            wr_uncond
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - 2 - IDX_BITS;

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] uncond_mem;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [XLEN-1:0]    target_mem [ENTRIES];

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;

    assign rd_idx    = rd_word[IDX_BITS-1:0];
    assign wr_idx    = wr_word[IDX_BITS-1:0];

    assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_word[XLEN-3:IDX_BITS]);
    assign rd_target = target_mem[rd_idx];
    assign rd_uncond = uncond_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Payload is not reset: an entry is only observable once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_mem[wr_idx]    <= wr_word[XLEN-3:IDX_BITS];
            target_mem[wr_idx] <= wr_target;
            uncond_mem[wr_idx] <= wr_uncond;
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Next-PC predictor for the IF stage: BTB + PHT of 2-bit counters + global
// history, selectable static-not-taken / bimodal / gshare direction policy.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   fetch_pc          - current fetch address (combinational lookup)
//   pred_next_pc      - predicted next fetch address
//   pred_taken        - prediction is taken
//   pred_hit          - BTB hit for fetch_pc
//   upd_*             - EX-stage resolution of a control-transfer instruction
//   stat_updates      - saturating count of accepted updates
//   stat_mispredicts  - saturating count of accepted updates flagged mispredicted
module gshare_branch_predictor
    import cpu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BTB_IDX_BITS = 4,
    parameter int PHT_IDX_BITS = 6,
    parameter int GHR_BITS     = 6,
    parameter int PRED_MODE    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] pred_next_pc,
    output logic            pred_taken,
    output logic            pred_hit,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_cond,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
);

    if (GHR_BITS > PHT_IDX_BITS || GHR_BITS < 0 || PRED_MODE > 2 || PRED_MODE < 0) begin : g_bad_params
        $fatal(1, "gshare_branch_predictor: illegal GHR_BITS/PRED_MODE combination");
    end

    localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;
    localparam int GHR_W       = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam bit USE_PHT     = (PRED_MODE != PRED_STATIC_NT);
    localparam bit USE_GHR     = (PRED_MODE == PRED_GSHARE) && (GHR_BITS > 0);

    ctr2_t            pht [PHT_ENTRIES];
    logic [GHR_W-1:0] ghr;

    logic [PHT_IDX_BITS-1:0] fetch_idx;
    logic [PHT_IDX_BITS-1:0] upd_idx;
    logic                    btb_hit;
    logic [XLEN-1:0]         btb_target;
    logic                    btb_uncond;
    logic                    unused_upd_pc_lsbs;

    // Without history (bimodal, or gshare with GHR_BITS=0) the index is the PC alone.
    function automatic logic [PHT_IDX_BITS-1:0] pht_index(
        input logic [PHT_IDX_BITS-1:0] pc_bits,
        input logic [GHR_W-1:0]        hist
    );
        if (USE_GHR) begin
            return pc_bits ^ PHT_IDX_BITS'(hist);
        end
        return pc_bits;
    endfunction

    function automatic ctr2_t ctr_next(input ctr2_t ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

    function automatic logic [31:0] stat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    assign unused_upd_pc_lsbs = ^upd_pc[1:0];

    assign fetch_idx = pht_index(fetch_pc[PHT_IDX_BITS+1:2], ghr);
    assign upd_idx   = pht_index(upd_pc[PHT_IDX_BITS+1:2], ghr);

    branch_target_buffer #(
        .XLEN     (XLEN),
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_word   (fetch_pc[XLEN-1:2]),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .rd_uncond (btb_uncond),
        .wr_en     (upd_valid && upd_taken),
        .wr_word   (upd_pc[XLEN-1:2]),
        .wr_target (upd_target),
        .wr_uncond (!upd_is_cond)
    );

    // Lookup sees pre-update state; there is deliberately no bypass from upd_*.
    assign pred_hit     = btb_hit;
    assign pred_taken   = USE_PHT && btb_hit && (btb_uncond || pht[fetch_idx][1]);
    assign pred_next_pc = pred_taken ? btb_target : fetch_pc + XLEN'(INST_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= WNT;
            end
            ghr              <= '0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            if (USE_PHT && upd_is_cond) begin
                pht[upd_idx] <= ctr_next(pht[upd_idx], upd_taken);
            end
            // History is only advanced at resolve time, never speculatively.
            if (USE_GHR && upd_is_cond) begin
                ghr <= GHR_W'({ghr, upd_taken});
            end
            stat_updates <= stat_inc(stat_updates);
            if (upd_mispredict) begin
                stat_mispredicts <= stat_inc(stat_mispredicts);
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_cond;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    logic [31:0] npc [3];
    logic        tk  [3];
    logic        hit [3];
    logic [31:0] su  [3];
    logic [31:0] sm  [3];

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    // Three configurations driven by the same stimulus: static, bimodal, gshare(GHR=2).
    gshare_branch_predictor #(.PRED_MODE(0)) dut_m0 (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .pred_next_pc(npc[0]), .pred_taken(tk[0]), .pred_hit(hit[0]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_updates(su[0]), .stat_mispredicts(sm[0]));

    gshare_branch_predictor #(.PRED_MODE(1)) dut_m1 (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .pred_next_pc(npc[1]), .pred_taken(tk[1]), .pred_hit(hit[1]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_updates(su[1]), .stat_mispredicts(sm[1]));

    gshare_branch_predictor #(.PRED_MODE(2), .GHR_BITS(2)) dut_m2 (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .pred_next_pc(npc[2]), .pred_taken(tk[2]), .pred_hit(hit[2]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_updates(su[2]), .stat_mispredicts(sm[2]));

    // ---------------- behavioural reference model ----------------
    localparam int MODE [3] = '{0, 1, 2};
    localparam int GB   [3] = '{6, 6, 2};

    bit          mv   [16];
    logic [25:0] mtag [16];
    logic [31:0] mtgt [16];
    bit          munc [16];
    int          pht  [3][64];
    int          ghr  [3];
    longint      msu  [3];
    longint      msm  [3];

    function automatic void exp_pred(input int i, input logic [31:0] pc,
                                     output logic t, output logic h, output logic [31:0] n);
        int b;
        int p;
        b = int'(pc[5:2]);
        p = int'(pc[7:2]) ^ ((MODE[i] == 2) ? ghr[i] : 0);
        h = mv[b] && (mtag[b] == pc[31:6]);
        t = (MODE[i] != 0) && h && (munc[b] || pht[i][p] >= 2);
        n = t ? mtgt[b] : pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 16; b++) mv[b] <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < 64; p++) pht[i][p] <= 1;
                ghr[i] <= 0;
                msu[i] <= 0;
                msm[i] <= 0;
            end
        end else if (upd_valid) begin
            for (int i = 0; i < 3; i++) begin
                int p;
                p = int'(upd_pc[7:2]) ^ ((MODE[i] == 2) ? ghr[i] : 0);
                if (upd_is_cond && MODE[i] != 0)
                    pht[i][p] <= upd_taken ? ((pht[i][p] == 3) ? 3 : pht[i][p] + 1)
                                           : ((pht[i][p] == 0) ? 0 : pht[i][p] - 1);
                if (upd_is_cond && MODE[i] == 2)
                    ghr[i] <= ((ghr[i] << 1) | int'(upd_taken)) & ((1 << GB[i]) - 1);
                if (msu[i] < 64'hFFFF_FFFF) msu[i] <= msu[i] + 1;
                if (upd_mispredict && msm[i] < 64'hFFFF_FFFF) msm[i] <= msm[i] + 1;
            end
            if (upd_taken) begin
                mv[int'(upd_pc[5:2])]   <= 1'b1;
                mtag[int'(upd_pc[5:2])] <= upd_pc[31:6];
                mtgt[int'(upd_pc[5:2])] <= upd_target;
                munc[int'(upd_pc[5:2])] <= !upd_is_cond;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic        et;
                logic        eh;
                logic [31:0] en;
                exp_pred(i, fetch_pc, et, eh, en);
                check($sformatf("m%0d_hit", i),   32'(hit[i]), 32'(eh));
                check($sformatf("m%0d_taken", i), 32'(tk[i]),  32'(et));
                check($sformatf("m%0d_npc", i),   npc[i],      en);
                check($sformatf("m%0d_stat_upd", i), su[i], msu[i][31:0]);
                check($sformatf("m%0d_stat_mis", i), sm[i], msm[i][31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic cond, input logic taken,
                          input logic [31:0] tgt, input logic mis);
        upd_valid = 1'b1; upd_pc = pc; upd_is_cond = cond;
        upd_taken = taken; upd_target = tgt; upd_mispredict = mis;
        tick();
        upd_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] pc;
        pc = ({$urandom_range(0, 1)} << 10) | ({$urandom_range(0, 63)} << 2) | $urandom_range(0, 3);
        return pc;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int late_mis;
        logic et, eh;
        logic [31:0] en;

        reset = 1'b1; fetch_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
        upd_is_cond = 1'b0; upd_taken = 1'b0; upd_target = 32'h0; upd_mispredict = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        fetch_pc = 32'h100;
        @(negedge clk);
        check("rst_hit",   32'(hit[1]), 32'h0);
        check("rst_taken", 32'(tk[1]),  32'h0);
        check("rst_npc",   npc[1],      32'h104);
        check("rst_stats", su[1] | sm[1], 32'h0);

        // Conditional taken branch trains BTB and counter 01 -> 10
        do_upd(32'h40, 1'b1, 1'b1, 32'h80, 1'b0);
        fetch_pc = 32'h40;
        @(negedge clk);
        check("bim_taken_npc", npc[1], 32'h80);
        check("bim_taken_hit", 32'(hit[1]), 32'h1);
        check("static_npc",    npc[0], 32'h44);

        // One not-taken resolution brings the counter back to 01
        do_upd(32'h40, 1'b1, 1'b0, 32'h80, 1'b0);
        @(negedge clk);
        check("bim_nt_npc",   npc[1], 32'h44);
        check("bim_nt_taken", 32'(tk[1]), 32'h0);

        // jal: BTB uncond entry predicts taken regardless of counter
        do_upd(32'h200, 1'b0, 1'b1, 32'h400, 1'b0);
        fetch_pc = 32'h200;
        @(negedge clk);
        check("jal_npc",        npc[1], 32'h400);
        check("jal_static_npc", npc[0], 32'h204);
        check("jal_pht_untouched", 32'(dut_m1.pht[0]), 32'h1);

        // Aliasing: 0x40 and 0x440 share BTB index 0
        do_upd(32'h40, 1'b1, 1'b1, 32'h80, 1'b0);
        fetch_pc = 32'h440;
        upd_valid = 1'b1; upd_pc = 32'h440; upd_is_cond = 1'b1;
        upd_taken = 1'b1; upd_target = 32'h900; upd_mispredict = 1'b0;
        @(negedge clk);
        check("alias_same_cycle_hit", 32'(hit[1]), 32'h0);
        tick();
        upd_valid = 1'b0;
        fetch_pc = 32'h40;
        @(negedge clk);
        check("alias_old_miss", 32'(hit[1]), 32'h0);
        fetch_pc = 32'h440;
        @(negedge clk);
        check("alias_new_hit", 32'(hit[1]), 32'h1);
        tick();

        // Gshare loop T,T,N x12 at 0x10; mispredict flag from the model's prediction
        late_mis = 0;
        for (int rep = 0; rep < 12; rep++) begin
            for (int k = 0; k < 3; k++) begin
                logic outcome;
                outcome = (k != 2);
                fetch_pc = 32'h10;
                @(negedge clk);
                exp_pred(2, 32'h10, et, eh, en);
                if (rep >= 4 && et != outcome) late_mis++;
                #4;
                do_upd(32'h10, 1'b1, outcome, 32'h4, et != outcome);
            end
        end
        check("gshare_loop_late_mispredicts", 32'(late_mis), 32'h0);

        // Reset wins over a same-cycle update
        reset = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_is_cond = 1'b1;
        upd_taken = 1'b1; upd_target = 32'h80; upd_mispredict = 1'b1;
        tick();
        reset = 1'b0; upd_valid = 1'b0;
        fetch_pc = 32'h40;
        @(negedge clk);
        check("rst_upd_hit",   32'(hit[1]), 32'h0);
        check("rst_upd_npc",   npc[2], 32'h44);
        check("rst_upd_stats", su[1] | sm[1] | su[2], 32'h0);
        check("rst_upd_ghr",   32'(dut_m2.ghr), 32'h0);

        // Randomized phase
        for (int c = 0; c < 600; c++) begin
            fetch_pc = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC : rnd_pc();
            reset = ($urandom_range(0, 79) == 0);
            upd_valid = $urandom_range(0, 2) != 0;
            upd_pc = rnd_pc();
            upd_is_cond = $urandom_range(0, 3) != 0;
            upd_taken = $urandom_range(0, 1);
            upd_target = {$urandom_range(0, 255), 2'b00};
            upd_mispredict = $urandom_range(0, 1);
            tick();
        end
        reset = 1'b0; upd_valid = 1'b0;
        fetch_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_npc", npc[0], 32'h0);
        tick();

        // Mispredict counter saturation
        force dut_m1.stat_mispredicts = 32'hFFFF_FFFF;
        msm[1] = 64'hFFFF_FFFF;
        #1;
        release dut_m1.stat_mispredicts;
        do_upd(32'h80, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("stat_mis_saturate", sm[1], 32'hFFFF_FFFF);
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
